// File: rtl/fuzz_harness_pkg.sv
// Shared types and default constants for the stimulus/MISR harness.
// State encoding plus default LFSR and MISR feedback masks.
package fuzz_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] DEF_TAPS      = 8'hB8;
  localparam logic [7:0] DEF_MISR_POLY = 8'h1D;

endpackage

// File: rtl/resp_misr.sv
// Multiple-input signature register compacting DUT responses.
// Clear wins over enable; state shifts left with feedback on the MSB.
module resp_misr #(
  parameter int              OUT_W     = 8,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(8'h1D)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] resp,
  output logic [OUT_W-1:0] signature
);

  logic [OUT_W-1:0] sig_q;
  logic [OUT_W-1:0] sig_d;

  // Next signature: shift, fold MSB through the polynomial, mix in resp.
  always_comb begin
    sig_d = {sig_q[OUT_W-2:0], 1'b0}
          ^ (sig_q[OUT_W-1] ? MISR_POLY : '0)
          ^ resp;
  end

  // Signature register, cleared at run start or reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      sig_q <= '0;
    end else if (enable) begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/stim_misr_harness.sv
// Drives LFSR vectors to a DUT and compacts its responses in a MISR.
// Each vector is held HOLD cycles; resp is sampled on the last one.
module stim_misr_harness
  import fuzz_harness_pkg::*;
#(
  parameter int               IN_W      = 8,
  parameter int               OUT_W     = 8,
  parameter int               NUM_VEC   = 21,
  parameter int               HOLD      = 2,
  parameter logic [IN_W-1:0]  SEED      = IN_W'(1),
  parameter logic [IN_W-1:0]  TAPS      = IN_W'(DEF_TAPS),
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  input  logic [OUT_W-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      vec_idx
);

  localparam logic [IN_W-1:0] SEED_EFF =
    (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [7:0]  HOLD_M1  = 8'(HOLD - 1);
  localparam logic [15:0] VEC_LAST = 16'(NUM_VEC);

  state_e          state_q;
  logic [IN_W-1:0] lfsr_q;
  logic [IN_W-1:0] lfsr_d;
  logic [IN_W-1:0] stim_q;
  logic [7:0]      hold_q;
  logic [15:0]     vec_q;
  logic            busy_q;
  logic            done_q;

  logic in_run;
  logic last_hold;
  logic last_vec;
  logic go;
  logic misr_en;
  logic misr_clr;

  assign in_run    = (state_q == ST_RUN);
  assign last_hold = (hold_q == HOLD_M1);
  assign last_vec  = (vec_q == VEC_LAST);
  assign go        = !in_run && start && !abort;
  assign misr_en   = in_run && !abort && last_hold;
  assign misr_clr  = !rst_n || go;
  assign lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // Run sequencer: hold/vector counting, LFSR stepping, stim register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_EFF;
      stim_q  <= '0;
      hold_q  <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        !in_run: begin
          if (abort) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q <= ST_RUN;
            lfsr_q  <= SEED_EFF;
            stim_q  <= '0;
            hold_q  <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        in_run: begin
          if (abort) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (!last_hold) begin
            hold_q <= hold_q + 8'd1;
          end else if (last_vec) begin
            state_q <= ST_DONE;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            hold_q <= '0;
            vec_q  <= vec_q + 16'd1;
            stim_q <= lfsr_q;
            lfsr_q <= lfsr_d;
          end
        end
      endcase
    end
  end

  resp_misr #(
    .OUT_W     (OUT_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk       (clk),
    .clear     (misr_clr),
    .enable    (misr_en),
    .resp      (resp),
    .signature (signature)
  );

  assign stim    = stim_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = vec_q;
  assign pass    = done_q && (signature == exp_sig);

endmodule

// File: doc/stim_misr_harness.md
STIM_MISR_HARNESS -- requirements
Module: stim_misr_harness

Interface
REQ-001 SHALL have parameter IN_W, default 8: stimulus width, 2..256.
REQ-002 SHALL have parameter OUT_W, default 8: response and signature width, 2..256.
REQ-003 SHALL have parameter NUM_VEC, default 21: number of pseudo-random vectors after the all-zero vector, 1..65535.
REQ-004 SHALL have parameter HOLD, default 2: cycles each vector is held, 1..255.
REQ-005 SHALL have parameter SEED, default 1: first pseudo-random vector; 0 is replaced by 1.
REQ-006 SHALL have parameter TAPS, default 8'hB8 zero-extended to IN_W: Galois LFSR feedback mask.
REQ-007 SHALL have parameter MISR_POLY, default 8'h1D zero-extended to OUT_W: MISR feedback mask.
REQ-008 SHALL have ports:
  clk       in   1       single clock, all logic on rising edge
  rst_n     in   1       synchronous active-low reset
  start     in   1       begin run; sampled in IDLE/DONE only
  abort     in   1       terminate run
  stim      out  IN_W    vector driven to DUT
  resp      in   OUT_W   DUT output
  exp_sig   in   OUT_W   golden signature
  busy      out  1       run in progress
  done      out  1       run complete, level
  pass      out  1       done and signature == exp_sig
  signature out  OUT_W   MISR state
  vec_idx   out  16      index of vector on stim

Function
REQ-009 SHALL implement states IDLE, RUN, DONE.
REQ-010 IDLE/DONE + start=1 at an edge SHALL enter RUN next cycle: busy=1, done=0, vec_idx=0, stim=0, signature cleared to 0.
REQ-011 Vector 0 SHALL be all-zero; vector 1 SHALL be SEED; vector k+1 = (v>>1) ^ (v[0] ? TAPS : 0).
REQ-012 Each vector SHALL be held exactly HOLD cycles; resp SHALL be sampled on the edge ending the hold's last cycle.
REQ-013 Per sample: signature <= (signature<<1 truncated to OUT_W) ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ resp.
REQ-014 After sampling vector NUM_VEC, SHALL enter DONE: busy=0, done=1, stim=0, signature frozen; run length exactly (NUM_VEC+1)*HOLD busy cycles.
REQ-015 pass SHALL equal done && (signature == exp_sig), combinational on exp_sig.
REQ-016 start while in RUN SHALL be ignored.
REQ-017 abort in RUN SHALL enter IDLE next cycle: busy=0, done=0, stim=0, signature retained; abort has priority over a same-edge sample.
REQ-018 abort and start together in DONE/IDLE SHALL be treated as abort (stay/go IDLE).
REQ-019 HOLD counter and vec_idx SHALL not wrap; vec_idx saturates at NUM_VEC.

Reset
REQ-020 rst_n=0 at an edge SHALL force IDLE, stim=0, busy=0, done=0, pass=0, signature=0, vec_idx=0, LFSR=SEED, including mid-run.
REQ-021 No asynchronous reset path SHALL exist.

Structure
REQ-022 State enum and default TAPS/MISR_POLY constants SHALL live in package fuzz_harness_pkg.
REQ-023 MISR SHALL be sub-module resp_misr (clear, enable, resp, signature), parametrised by OUT_W and MISR_POLY.
REQ-024 LFSR, hold counter, vector counter and FSM SHALL reside in stim_misr_harness.

Verification (IN_W=8, OUT_W=4, NUM_VEC=3, HOLD=2, SEED=1, TAPS=8'hB8, MISR_POLY=4'h9 unless stated)
REQ-025 start pulse, resp tied 0 -> stim 00,00,01,01,B8,B8,5C,5C over 8 busy cycles; done=1 cycle 9; signature=0.
REQ-026 resp=stim[3:0] loopback, exp_sig=4'h1 -> done=1, signature=4'h1, pass=1; exp_sig=4'h2 -> pass=0.
REQ-027 abort at busy cycle 3 -> IDLE next cycle, stim=0, done=0; new start reruns full 8-cycle sequence from 00.
REQ-028 rst_n=0 at busy cycle 5 -> all outputs reset values next cycle; start afterwards reproduces REQ-025 exactly.
REQ-029 start held high through run and DONE -> no restart mid-run; new run begins cycle after DONE is sampled with start=1.
REQ-030 SEED=0 -> vector 1 equals 8'h01.
